// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer
// Drives an SPI master's register interface on behalf of the host. Host words
// queue in a TX FIFO. For each word the sequencer writes the master's TX
// register, polls READY every POLL_GAP idle cycles, then reads the RX register
// and queues the received word in an RX FIFO for the host. If READY does not
// rise within TIMEOUT polls, the word is dropped and a sticky error is raised.
//
// Ports
//   clk, rst_int             clock, asynchronous active-high reset
//   tx_data/tx_valid/tx_ready host push side of the TX FIFO
//   rx_data/rx_valid/rx_ready host pop side of the RX FIFO
//   tx_level, rx_level        FIFO occupancies
//   busy                      transfer in progress or TX words pending
//   err_timeout, err_clr      sticky poll-timeout flag and its clear
//   m_*                       registered master register-bus strobes/data;
//                             m_data_out is the master's combinational read data
module spi_xfer_sequencer #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 3,
    parameter int                FIFO_LOG2  = 3,
    parameter logic [ADDR_W-1:0] TX_ADDR    = 3'd2,
    parameter logic [ADDR_W-1:0] RX_ADDR    = 3'd3,
    parameter logic [ADDR_W-1:0] READY_ADDR = 3'd1,
    parameter int                POLL_GAP   = 8,
    parameter int                TIMEOUT    = 4096
) (
    input  logic                 clk,
    input  logic                 rst_int,
    input  logic [DATA_W-1:0]    tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_W-1:0]    rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [FIFO_LOG2:0]   tx_level,
    output logic [FIFO_LOG2:0]   rx_level,
    output logic                 busy,
    output logic                 err_timeout,
    input  logic                 err_clr,
    output logic [DATA_W-1:0]    m_data_in,
    input  logic [DATA_W-1:0]    m_data_out,
    output logic [ADDR_W-1:0]    m_address,
    output logic                 m_sel,
    output logic                 m_read,
    output logic                 m_write
);
    localparam int DEPTH  = 1 << FIFO_LOG2;
    localparam int LVL_W  = FIFO_LOG2 + 1;
    localparam int GAP_W  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int PCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEND  = 3'd1,
        S_GAP   = 3'd2,
        S_POLL  = 3'd3,
        S_FETCH = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [PCNT_W-1:0]   poll_q, poll_d;
    logic [PCNT_W-1:0]   poll_inc_s;
    logic                err_q, err_d, err_set_s;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic                m_sel_q, m_sel_d, m_read_q, m_read_d, m_write_q, m_write_d;

    // ---------------- TX FIFO ----------------
    logic [DATA_W-1:0]    tx_mem_q [DEPTH];
    logic [FIFO_LOG2-1:0] tx_wr_q, tx_rd_q;
    logic [LVL_W-1:0]     tx_cnt_q;
    logic                 tx_push_s, tx_pop_s, tx_empty_s;

    assign tx_ready   = (tx_cnt_q != FULL_LVL);
    assign tx_empty_s = (tx_cnt_q == LVL_W'(0));
    assign tx_push_s  = tx_valid & tx_ready;
    assign tx_pop_s   = (state_q == S_SEND);
    assign tx_level   = tx_cnt_q;

    // TX storage; emptiness is tracked by the pointers, so no reset is needed
    always_ff @(posedge clk) begin
        if (tx_push_s) begin
            tx_mem_q[tx_wr_q] <= tx_data;
        end
    end

    // TX pointers and occupancy
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (tx_push_s) tx_wr_q <= tx_wr_q + FIFO_LOG2'(1);
            if (tx_pop_s)  tx_rd_q <= tx_rd_q + FIFO_LOG2'(1);
            tx_cnt_q <= tx_cnt_q + LVL_W'(tx_push_s) - LVL_W'(tx_pop_s);
        end
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_W-1:0]    rx_mem_q [DEPTH];
    logic [FIFO_LOG2-1:0] rx_wr_q, rx_rd_q;
    logic [LVL_W-1:0]     rx_cnt_q;
    logic                 rx_fetch_s, rx_push_s, rx_pop_s, rx_full_s;

    assign rx_full_s = (rx_cnt_q == FULL_LVL);
    assign rx_valid  = (rx_cnt_q != LVL_W'(0));
    assign rx_push_s = rx_fetch_s & ~rx_full_s;
    assign rx_pop_s  = rx_valid & rx_ready;
    assign rx_data   = rx_mem_q[rx_rd_q];
    assign rx_level  = rx_cnt_q;

    // RX storage; written with the master's read data during FETCH
    always_ff @(posedge clk) begin
        if (rx_push_s) begin
            rx_mem_q[rx_wr_q] <= m_data_out;
        end
    end

    // RX pointers and occupancy
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (rx_push_s) rx_wr_q <= rx_wr_q + FIFO_LOG2'(1);
            if (rx_pop_s)  rx_rd_q <= rx_rd_q + FIFO_LOG2'(1);
            rx_cnt_q <= rx_cnt_q + LVL_W'(rx_push_s) - LVL_W'(rx_pop_s);
        end
    end

    // ---------------- Sequencer FSM ----------------
    assign poll_inc_s = poll_q + PCNT_W'(1);

    // Next-state logic; READY is sampled from the master in the POLL cycle itself
    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        poll_d     = poll_q;
        err_set_s  = 1'b0;
        rx_fetch_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Requiring RX space here guarantees FETCH always has room
                if (!tx_empty_s && !rx_full_s) begin
                    state_d = S_SEND;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEND: begin
                poll_d  = '0;
                gap_d   = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_q == GAP_W'(POLL_GAP - 1)) begin
                    gap_d   = '0;
                    state_d = S_POLL;
                end else begin
                    gap_d   = gap_q + GAP_W'(1);
                    state_d = S_GAP;
                end
            end
            S_POLL: begin
                if (m_data_out[0]) begin
                    state_d = S_FETCH;
                end else if (poll_inc_s == PCNT_W'(TIMEOUT)) begin
                    err_set_s = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    poll_d  = poll_inc_s;
                    state_d = S_GAP;
                end
            end
            S_FETCH: begin
                rx_fetch_s = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus outputs are decoded from the upcoming state so the registered strobes
    // line up exactly with the SEND/POLL/FETCH cycles
    always_comb begin
        m_data_d  = '0;
        m_addr_d  = '0;
        m_sel_d   = 1'b0;
        m_read_d  = 1'b0;
        m_write_d = 1'b0;
        case (state_d)
            S_SEND: begin
                m_data_d  = tx_mem_q[tx_rd_q];
                m_addr_d  = TX_ADDR;
                m_sel_d   = 1'b1;
                m_write_d = 1'b1;
            end
            S_POLL: begin
                m_addr_d = READY_ADDR;
                m_sel_d  = 1'b1;
                m_read_d = 1'b1;
            end
            S_FETCH: begin
                m_addr_d = RX_ADDR;
                m_sel_d  = 1'b1;
                m_read_d = 1'b1;
            end
            default: begin
                m_addr_d = '0;
            end
        endcase
    end

    // Sticky timeout flag: a new timeout wins over a simultaneous clear
    always_comb begin
        if (err_set_s) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // FSM, counters, error flag and registered bus outputs
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            state_q   <= S_IDLE;
            gap_q     <= '0;
            poll_q    <= '0;
            err_q     <= 1'b0;
            m_data_q  <= '0;
            m_addr_q  <= '0;
            m_sel_q   <= 1'b0;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            poll_q    <= poll_d;
            err_q     <= err_d;
            m_data_q  <= m_data_d;
            m_addr_q  <= m_addr_d;
            m_sel_q   <= m_sel_d;
            m_read_q  <= m_read_d;
            m_write_q <= m_write_d;
        end
    end

    assign m_data_in   = m_data_q;
    assign m_address   = m_addr_q;
    assign m_sel       = m_sel_q;
    assign m_read      = m_read_q;
    assign m_write     = m_write_q;
    assign err_timeout = err_q;
    assign busy        = (state_q != S_IDLE) | ~tx_empty_s;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Bench for spi_xfer_sequencer: a behavioural SPI master register model, a
// table of single-word transfers, directed corner sequences, and a random
// stream checked against a queue scoreboard.
module tb_spi_xfer_sequencer;
    logic        clk = 1'b0;
    logic        rst_int;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [3:0]  tx_level;
    logic [3:0]  rx_level;
    logic        busy;
    logic        err_timeout;
    logic        err_clr;
    logic [31:0] m_data_in;
    logic [31:0] m_data_out;
    logic [2:0]  m_address;
    logic        m_sel;
    logic        m_read;
    logic        m_write;

    spi_xfer_sequencer #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_int(rst_int),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_level(tx_level), .rx_level(rx_level), .busy(busy),
        .err_timeout(err_timeout), .err_clr(err_clr),
        .m_data_in(m_data_in), .m_data_out(m_data_out), .m_address(m_address),
        .m_sel(m_sel), .m_read(m_read), .m_write(m_write)
    );

    always #5 clk = ~clk;

    // Master model: response word is a fixed transform of the last TX word
    function automatic logic [31:0] xform(input logic [31:0] w);
        return {~w[31:16], w[3:0], w[7:4], w[11:8], w[15:12]};
    endfunction

    int          need  = 1;     // READY returns 1 on this poll number
    bit          stall = 1'b0;  // READY never returns 1
    int          poll_idx = 0;
    int          wr_cnt = 0, rdy_cnt = 0, rxrd_cnt = 0;
    logic [31:0] last_tx = 32'h0;

    always @(posedge clk) begin
        if (m_sel && m_write && m_address == 3'd2) begin
            last_tx  <= m_data_in;
            poll_idx <= 0;
            wr_cnt   <= wr_cnt + 1;
        end
        if (m_sel && m_read && m_address == 3'd1) begin
            poll_idx <= poll_idx + 1;
            rdy_cnt  <= rdy_cnt + 1;
        end
        if (m_sel && m_read && m_address == 3'd3) begin
            rxrd_cnt <= rxrd_cnt + 1;
        end
    end

    always_comb begin
        m_data_out = 32'h0;
        if (m_sel && m_read && m_address == 3'd1) begin
            m_data_out = {31'h0, (!stall && (poll_idx + 1 >= need))};
        end else if (m_sel && m_read && m_address == 3'd3) begin
            m_data_out = xform(last_tx);
        end
    end

    int          errors = 0, checks = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic push_wait(input logic [31:0] w);
        int n = 0;
        while (!tx_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("push_window", {31'h0, tx_ready}, 32'h1);
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic pop_expect(input string nm);
        int n = 0;
        logic [31:0] e;
        while (!rx_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        chk({nm, "_valid"}, {31'h0, rx_valid}, 32'h1);
        chk({nm, "_data"}, rx_data, e);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || rx_valid) && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    typedef struct {
        logic [31:0] word;
        int          need;
        logic [31:0] resp;
        int          polls;
        int          lat;
    } vec_t;

    vec_t        vecs[4];
    int          n, b_wr, b_rdy, b_rx;
    logic [31:0] w;

    initial begin
        // push-to-rx_valid latency = POLL_GAP + 4 + (POLL_GAP + 1) per extra poll
        vecs[0] = '{32'hA5A5_1234, 3, 32'h5A5A_4321, 3, 30};
        vecs[1] = '{32'h0000_0000, 1, 32'hFFFF_0000, 1, 12};
        vecs[2] = '{32'hFFFF_FFFF, 2, 32'h0000_FFFF, 2, 21};
        vecs[3] = '{32'h1234_5678, 4, 32'hEDCB_8765, 4, 39};

        rst_int = 1'b1; tx_data = 32'h0; tx_valid = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_m_sel", {31'h0, m_sel}, 32'h0);
        chk("rst_m_strobes", {30'h0, m_read, m_write}, 32'h0);
        chk("rst_m_addr_data", m_data_in | {29'h0, m_address}, 32'h0);
        chk("rst_tx_ready", {31'h0, tx_ready}, 32'h1);
        chk("rst_levels_flags", {22'h0, tx_level, rx_level, rx_valid, busy}, 32'h0);
        chk("rst_err", {31'h0, err_timeout}, 32'h0);
        rst_int = 1'b0;
        @(negedge clk);

        // Table: one word at a time, varying READY latency
        for (int i = 0; i < 4; i++) begin
            need = vecs[i].need; stall = 1'b0;
            b_wr = wr_cnt; b_rdy = rdy_cnt; b_rx = rxrd_cnt;
            push_wait(vecs[i].word);
            n = 0;
            while (!rx_valid && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("vec_latency", n, vecs[i].lat);
            chk("vec_writes", wr_cnt - b_wr, 32'd1);
            chk("vec_tx_word", last_tx, vecs[i].word);
            chk("vec_polls", rdy_cnt - b_rdy, vecs[i].polls);
            chk("vec_rx_reads", rxrd_cnt - b_rx, 32'd1);
            chk("vec_err", {31'h0, err_timeout}, 32'h0);
            exp_q.push_back(vecs[i].resp);
            pop_expect("vec_rx");
        end

        // Reset in the SEND cycle aborts the transfer
        b_wr = wr_cnt;
        push_wait(32'h0BAD_0001);
        n = 0;
        while (!m_write && n < 50) begin
            @(negedge clk);
            n++;
        end
        rst_int = 1'b1;
        @(negedge clk);
        chk("midrst_m", {28'h0, m_sel, m_read, m_write, |m_address}, 32'h0);
        chk("midrst_levels_busy", {23'h0, tx_level, rx_level, busy}, 32'h0);
        rst_int = 1'b0;
        repeat (30) @(negedge clk);
        chk("midrst_no_rx", {28'h0, rx_level}, 32'h0);
        chk("midrst_no_write", wr_cnt - b_wr, 32'd0);

        // Full TX: one word in flight with the master stalled, then 9 back-to-back
        stall = 1'b1; need = 1;
        push_wait(32'hC0DE_0000);
        exp_q.push_back(xform(32'hC0DE_0000));
        for (int k = 1; k <= 9; k++) begin
            tx_data  = 32'hC0DE_0000 + k;
            tx_valid = 1'b1;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        chk("full_tx_ready", {31'h0, tx_ready}, 32'h0);
        chk("full_tx_level", {28'h0, tx_level}, 32'd8);
        for (int k = 1; k <= 8; k++) exp_q.push_back(xform(32'hC0DE_0000 + k));
        stall = 1'b0;
        for (int k = 0; k < 9; k++) pop_expect("full_rx");
        wait_idle();
        chk("full_drained_level", {28'h0, tx_level}, 32'd0);

        // RX full: no pops, 10 words
        b_wr = wr_cnt;
        for (int k = 0; k < 10; k++) begin
            push_wait(32'h5100_0000 + k);
            exp_q.push_back(xform(32'h5100_0000 + k));
        end
        repeat (150) @(negedge clk);
        chk("rxfull_writes", wr_cnt - b_wr, 32'd8);
        chk("rxfull_rx_level", {28'h0, rx_level}, 32'd8);
        chk("rxfull_tx_level", {28'h0, tx_level}, 32'd2);
        chk("rxfull_busy", {31'h0, busy}, 32'h1);
        pop_expect("rxfull_pop");
        repeat (40) @(negedge clk);
        chk("rxfull_one_more", wr_cnt - b_wr, 32'd9);
        chk("rxfull_rx_level2", {28'h0, rx_level}, 32'd8);
        chk("rxfull_tx_level2", {28'h0, tx_level}, 32'd1);
        for (int k = 0; k < 9; k++) pop_expect("rxfull_rx");

        // Timeout with READY held low
        wait_idle();
        stall = 1'b1;
        b_rdy = rdy_cnt; b_rx = rxrd_cnt;
        push_wait(32'h7777_0001);
        n = 0;
        while (!err_timeout && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("to_flag", {31'h0, err_timeout}, 32'h1);
        chk("to_polls", rdy_cnt - b_rdy, 32'd4);
        chk("to_no_rx_read", rxrd_cnt - b_rx, 32'd0);
        chk("to_no_rx_push", {28'h0, rx_level}, 32'd0);
        chk("to_idle", {31'h0, busy}, 32'h0);
        stall = 1'b0; need = 1;
        push_wait(32'h7777_0002);
        exp_q.push_back(xform(32'h7777_0002));
        pop_expect("to_next_word");
        chk("to_sticky", {31'h0, err_timeout}, 32'h1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("to_clear", {31'h0, err_timeout}, 32'h0);
        wait_idle();
        stall = 1'b1;
        push_wait(32'h7777_0003);
        n = 0;
        while (!(m_sel && m_read && m_address == 3'd1 && poll_idx == 3) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("to_pre_set", {31'h0, err_timeout}, 32'h0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("to_set_over_clr", {31'h0, err_timeout}, 32'h1);
        stall = 1'b0;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;

        // Random stream with interleaved pops
        for (int i = 0; i < 20; i++) begin
            w = $urandom;
            need = $urandom_range(1, 3);
            if (rx_level >= 4'd6) pop_expect("rand_pop");
            push_wait(w);
            exp_q.push_back(xform(w));
            if ($urandom_range(0, 1) == 1 && rx_valid) pop_expect("rand_pop");
        end
        n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            pop_expect("rand_drain");
            n++;
        end
        wait_idle();
        chk("end_idle", {22'h0, tx_level, rx_level, busy, err_timeout}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
